mem_stage: RTL
==============

Name: mem_stage

Overview:
- MEM stage of the RV64 five-stage pipeline, directly downstream of EXE_Stage; consumes its EX/MEM register outputs.
- Performs 64-bit doubleword loads/stores (ld/sd) against a local data memory and drives the MEM/WB pipeline register.
- A configurable wait-state FSM models a slow memory and back-pressures EXE and upstream stages via StallM.

Parameters:
- XLEN, 64, datapath width.
- DEPTH, 256, data memory size in doublewords; power of two.
- MEM_LAT, 0, extra wait cycles per memory access; 0 means single-cycle memory; legal range 0..15.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- RegWriteM  input  1  register-write control from EX/MEM.
- MemWriteM  input  1  store enable.
- MemReadM  input  1  load enable.
- MemToRegM  input  1  writeback select: 1 = load data, 0 = ALU result.
- RD_M  input  5  destination register.
- WriteDataM  input  XLEN  store data (rs2).
- ALU_ResultM  input  XLEN  byte address for loads/stores, or ALU result.
- StallM  output  1  hold EX/MEM and all upstream pipeline registers this cycle.
- RegWriteW  output  1  registered RegWrite to WB.
- MemToRegW  output  1  registered MemToReg.
- RD_W  output  5  registered destination register.
- ReadDataW  output  XLEN  registered load data.
- ALU_ResultW  output  XLEN  registered ALU result.
- MisalignW  output  1  registered flag: the access had address[2:0] != 0.

Behaviour:
- Reset, asynchronous:
  - All W outputs go to 0.
  - FSM goes to IDLE and the wait counter to 0, so StallM=0.
  - Memory contents are not cleared.
- An access is MemReadM or MemWriteM. If both are set, treat it as a store only; the load is ignored and ReadDataW=0.
- Index = ALU_ResultM[3+log2(DEPTH)-1:3]. Upper address bits are ignored, so addresses wrap modulo DEPTH*8.
- FSM states are IDLE and WAIT; counter is 4 bits.
  - IDLE, access, MEM_LAT>0: StallM=1, next WAIT, cnt=MEM_LAT-1; MEM/WB loads a bubble.
  - IDLE, access, MEM_LAT=0: completion cycle.
  - IDLE, no access: pass-through cycle; StallM=0; MEM/WB captures the inputs.
  - WAIT, cnt!=0: StallM=1, cnt decrements, MEM/WB loads a bubble.
  - WAIT, cnt=0: completion cycle, StallM=0, next IDLE.
- An access therefore occupies exactly MEM_LAT+1 cycles. StallM is high for the first MEM_LAT of those cycles.
- StallM is combinational from the state, the counter and MemReadM/MemWriteM.
- Completion cycle, at the rising edge:
  - A store writes WriteDataM to mem[index].
  - A load captures mem[index] (combinational read) into ReadDataW.
  - RegWriteW, MemToRegW, RD_W and ALU_ResultW capture their inputs.
- Bubble: RegWriteW=0, MemToRegW=0 and MisalignW=0; the other W outputs hold their previous values.
- Inputs are held stable by upstream while StallM=1. The values sampled at the completion edge are authoritative.
- Misaligned access (address[2:0]!=0):
  - Store is suppressed.
  - Load returns ReadDataW=0.
  - MisalignW=1 for that instruction.
  - Timing and stall behaviour are unchanged.
- Store followed by a load to the same address in the next instruction: the load returns the new data, since the write commits at the earlier edge.
- Reset asserted during WAIT: the pending store is never written, the FSM goes to IDLE, and the stall drops immediately.
- Loads with RD_M=0 are passed through unchanged; register-file x0 handling belongs to WB.

Decomposition:
- Shared package pipeline_pkg:
  - XLEN.
  - mem_state_t enum {IDLE, WAIT}.
  - Doubleword offset width constant (3).
- Sub-module data_memory (DEPTH x XLEN):
  - Combinational read port.
  - Synchronous write port with write enable.
  - No reset.
- mem_stage contains the FSM, the counter, the alignment check and the MEM/WB register.

Test Plan:
- MEM_LAT=0:
  - Store WriteDataM=64'hDEADBEEF_CAFEF00D to address 64'h10.
  - Next cycle, load the same address with MemToRegM=1, RD_M=5.
  - Required: next edge gives ReadDataW=64'hDEADBEEF_CAFEF00D, RD_W=5, RegWriteW=1; StallM never asserted.
- MEM_LAT=2, load from address 64'h18:
  - Required: StallM=1 for exactly 2 cycles.
  - Required: RegWriteW=0 during those cycles.
  - Required: the third edge delivers ReadDataW with RegWriteW=1.
- ALU op, no memory access, ALU_ResultM=30, RD_M=7, RegWriteM=1:
  - Required: ALU_ResultW=30, RD_W=7 after one edge; StallM=0 for both MEM_LAT values.
- Misaligned store to 64'h13, then aligned load from 64'h10:
  - Required: the store gives MisalignW=1.
  - Required: the load returns the prior contents unchanged.
- MEM_LAT=3, store to 64'h20, reset asserted during the second stall cycle:
  - Required: outputs go to 0 asynchronously and StallM=0.
  - Required: a later load from 64'h20 shows the old data.
- Address wrap, DEPTH=256:
  - Store to 64'h800 (index 0), then load from 64'h0.
  - Required: the stored value is returned.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared datapath width, MEM-stage FSM states and doubleword offset width.
package pipeline_pkg;
   localparam int XLEN   = 64;
   localparam int DW_OFF = 3;
   typedef enum logic {IDLE, WAIT} mem_state_t;
endpackage

// File: rtl/data_memory.sv
// data_memory: DEPTH x XLEN array, combinational read, synchronous write, contents survive reset.
module data_memory
   import pipeline_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            we_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] rdata_o
);
   logic [XLEN-1:0] mem_q [DEPTH];

   always_ff @(posedge clk)
      if (we_i) mem_q[addr_i] <= wdata_i;

   assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: doubleword load/store stage with a wait-state FSM that stalls upstream while a
// slow access is in flight, and the MEM/WB pipeline register.
module mem_stage
   import pipeline_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int MEM_LAT = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            RegWriteM,
   input  logic            MemWriteM,
   input  logic            MemReadM,
   input  logic            MemToRegM,
   input  logic [4:0]      RD_M,
   input  logic [XLEN-1:0] WriteDataM,
   input  logic [XLEN-1:0] ALU_ResultM,
   output logic            StallM,
   output logic            RegWriteW,
   output logic            MemToRegW,
   output logic [4:0]      RD_W,
   output logic [XLEN-1:0] ReadDataW,
   output logic [XLEN-1:0] ALU_ResultW,
   output logic            MisalignW
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] LAT = 4'(MEM_LAT);

   mem_state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic access, misal, store, load, hold, we;
   logic [AW-1:0] idx;
   logic [XLEN-1:0] rdata;

   assign access = MemReadM | MemWriteM;
   assign misal  = access & (ALU_ResultM[DW_OFF-1:0] != '0);
   assign store  = MemWriteM & ~misal;
   assign load   = MemReadM & ~MemWriteM & ~misal;
   assign idx    = ALU_ResultM[DW_OFF +: AW];

   data_memory #(.DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .we_i    (we),
      .addr_i  (idx),
      .wdata_i (WriteDataM),
      .rdata_o (rdata)
   );

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE && access && MEM_LAT != 0) begin
         state_d = WAIT;
         cnt_d   = LAT - 4'd1;
      end else if (state_q == WAIT) begin
         state_d = cnt_q == 4'd0 ? IDLE : WAIT;
         cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
      end
   end

   // Reset masks the stall and the write so a pending store dies with the reset.
   always_comb begin
      hold   = state_q == WAIT ? cnt_q != 4'd0 : access && MEM_LAT != 0;
      StallM = hold & ~reset;
      we     = store & ~hold & ~reset;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         RegWriteW   <= 1'b0;
         MemToRegW   <= 1'b0;
         RD_W        <= '0;
         ReadDataW   <= '0;
         ALU_ResultW <= '0;
         MisalignW   <= 1'b0;
      end else if (hold) begin
         RegWriteW   <= 1'b0;
         MemToRegW   <= 1'b0;
         MisalignW   <= 1'b0;
      end else begin
         RegWriteW   <= RegWriteM;
         MemToRegW   <= MemToRegM;
         RD_W        <= RD_M;
         ReadDataW   <= load ? rdata : '0;
         ALU_ResultW <= ALU_ResultM;
         MisalignW   <= misal;
      end
endmodule
